axi4_lite_slave: RTL and testbench

AXI4_LITE_SLAVE -- requirements
Module: axi4_lite_slave

---
 rtl/axi4_lite_slave.sv | 182 ++++++++++++++++++
 tb/tb_axi4_lite_slave.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_slave.sv
// AXI4-Lite register slave: NUM_REGS x 32-bit registers with byte strobes, SLVERR outside the register window.
// Latency: B response one cycle after the AW/W pair is complete; R data one cycle after the AR handshake.
// Backpressure: AW/W stall while a B response is outstanding; AR stalls while a read response is outstanding.
module axi4_lite_slave #(
  parameter int ADDRESS    = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [ADDRESS-1:0]    S_AWADDR,
  input  logic                  S_AWVALID,
  output logic                  S_AWREADY,
  input  logic [DATA_WIDTH-1:0] S_WDATA,
  input  logic [3:0]            S_WSTRB,
  input  logic                  S_WVALID,
  output logic                  S_WREADY,
  output logic [1:0]            S_BRESP,
  output logic                  S_BVALID,
  input  logic                  S_BREADY,
  input  logic [ADDRESS-1:0]    S_ARADDR,
  input  logic                  S_ARVALID,
  output logic                  S_ARREADY,
  output logic [DATA_WIDTH-1:0] S_RDATA,
  output logic [1:0]            S_RRESP,
  output logic                  S_RVALID,
  input  logic                  S_RREADY
);

  localparam int                 IDX_W      = $clog2(NUM_REGS);
  localparam logic [ADDRESS-1:0] ADDR_LIMIT = ADDRESS'(NUM_REGS * 4);
  localparam logic [1:0]         RESP_OKAY  = 2'b00;
  localparam logic [1:0]         RESP_SLVERR = 2'b10;

  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

  // Write-side state
  logic                  aw_held_q, aw_held_d;
  logic [ADDRESS-1:0]    awaddr_q, awaddr_d;
  logic                  w_held_q, w_held_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;

  // Read-side state
  r_state_e              r_state_q, r_state_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  logic                  aw_hs, w_hs, commit;
  logic [ADDRESS-1:0]    wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [3:0]            wr_strb;
  logic                  wr_in_range, rd_in_range;
  logic [IDX_W-1:0]      wr_idx, rd_idx;

  // READYs depend only on flops, never on the VALID inputs
  assign S_AWREADY = !aw_held_q && !bvalid_q;
  assign S_WREADY  = !w_held_q && !bvalid_q;
  assign S_BVALID  = bvalid_q;
  assign S_BRESP   = bresp_q;
  assign S_ARREADY = (r_state_q == R_IDLE);
  assign S_RVALID  = (r_state_q == R_DATA);
  assign S_RDATA   = rdata_q;
  assign S_RRESP   = rresp_q;

  assign aw_hs       = S_AWVALID && S_AWREADY;
  assign w_hs        = S_WVALID && S_WREADY;
  // A channel already held wins over the live bus; otherwise the live beat is the one handshaking now
  assign wr_addr     = aw_held_q ? awaddr_q : S_AWADDR;
  assign wr_data     = w_held_q ? wdata_q : S_WDATA;
  assign wr_strb     = w_held_q ? wstrb_q : S_WSTRB;
  assign wr_in_range = (wr_addr < ADDR_LIMIT);
  assign wr_idx      = wr_addr[2 +: IDX_W];
  assign commit      = (aw_held_q || aw_hs) && (w_held_q || w_hs) && !bvalid_q;
  assign rd_in_range = (S_ARADDR < ADDR_LIMIT);
  assign rd_idx      = S_ARADDR[2 +: IDX_W];

  // Write channel capture, commit detection and B response generation
  always_comb begin
    aw_held_d = aw_held_q;
    awaddr_d  = awaddr_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = S_AWADDR;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = S_WDATA;
      wstrb_d  = S_WSTRB;
    end
    if (commit) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_in_range ? RESP_OKAY : RESP_SLVERR;
    end
    // Held beats stay parked until the response is consumed, which is what keeps AW/W stalled
    if (bvalid_q && S_BREADY) begin
      bvalid_d  = 1'b0;
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end
  end

  // Register file update: byte-masked write at commit, nothing for out-of-range addresses
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (commit && wr_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) begin
          regs_d[wr_idx][8*b +: 8] = wr_data[8*b +: 8];
        end
      end
    end
  end

  // Read FSM next state; data is sampled from regs_q so a same-edge commit is not visible yet
  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (S_ARVALID) begin
          r_state_d = R_DATA;
          rdata_d   = rd_in_range ? regs_q[rd_idx] : '0;
          rresp_d   = rd_in_range ? RESP_OKAY : RESP_SLVERR;
        end
      end
      R_DATA: begin
        if (S_RREADY) begin
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // State registers with synchronous reset that also drops any in-flight transaction
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_held_q <= 1'b0;
      awaddr_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      r_state_q <= R_IDLE;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      aw_held_q <= aw_held_d;
      awaddr_q  <= awaddr_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

endmodule

// File: tb/tb_axi4_lite_slave.sv
// Directed bench for axi4_lite_slave: write/read, strobes, SLVERR, backpressure, reset abort, read/commit race.
// Inputs are driven 1 time unit after the rising edge and outputs are sampled there too.
// Every bounded wait that expires is reported as a failed check.
module tb_axi4_lite_slave;

  logic        ACLK;
  logic        ARESET;
  logic [31:0] S_AWADDR;
  logic        S_AWVALID;
  logic        S_AWREADY;
  logic [31:0] S_WDATA;
  logic [3:0]  S_WSTRB;
  logic        S_WVALID;
  logic        S_WREADY;
  logic [1:0]  S_BRESP;
  logic        S_BVALID;
  logic        S_BREADY;
  logic [31:0] S_ARADDR;
  logic        S_ARVALID;
  logic        S_ARREADY;
  logic [31:0] S_RDATA;
  logic [1:0]  S_RRESP;
  logic        S_RVALID;
  logic        S_RREADY;

  int checks = 0;
  int errors = 0;

  axi4_lite_slave #(.ADDRESS(32), .DATA_WIDTH(32), .NUM_REGS(8)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Full write with AW and W presented together and BREADY high; returns the B response
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp);
    bit aw_fire, w_fire, aw_done, w_done;
    int n;
    aw_done = 0; w_done = 0; n = 0;
    S_AWADDR = a; S_WDATA = d; S_WSTRB = s;
    S_AWVALID = 1; S_WVALID = 1; S_BREADY = 1;
    while (!(aw_done && w_done) && n < 20) begin
      aw_fire = S_AWVALID && S_AWREADY;
      w_fire  = S_WVALID && S_WREADY;
      tick();
      if (aw_fire) begin S_AWVALID = 0; aw_done = 1; end
      if (w_fire)  begin S_WVALID = 0;  w_done = 1;  end
      n++;
    end
    n = 0;
    while (!S_BVALID && n < 20) begin tick(); n++; end
    checks++;
    if (!S_BVALID) begin
      errors++;
      $display("FAIL write_bvalid_timeout addr=%h got BVALID=%b want 1", a, S_BVALID);
    end
    resp = S_BRESP;
    tick();
    S_BREADY = 0; S_AWVALID = 0; S_WVALID = 0;
  endtask

  // Single read with RREADY high; returns data and response
  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    n = 0;
    S_ARADDR = a; S_ARVALID = 1; S_RREADY = 1;
    while (!S_ARREADY && n < 20) begin tick(); n++; end
    tick();
    S_ARVALID = 0;
    n = 0;
    while (!S_RVALID && n < 20) begin tick(); n++; end
    checks++;
    if (!S_RVALID) begin
      errors++;
      $display("FAIL read_rvalid_timeout addr=%h got RVALID=%b want 1", a, S_RVALID);
    end
    d = S_RDATA; resp = S_RRESP;
    tick();
    S_RREADY = 0;
  endtask

  task automatic test_reset();
    ARESET = 1;
    tick(); tick();
    checks++; if (S_BVALID !== 1'b0) begin errors++; $display("FAIL rst_bvalid_during got %b want 0", S_BVALID); end
    checks++; if (S_RVALID !== 1'b0) begin errors++; $display("FAIL rst_rvalid_during got %b want 0", S_RVALID); end
    ARESET = 0;
    tick();
    checks++; if (S_BVALID !== 1'b0) begin errors++; $display("FAIL rst_bvalid got %b want 0", S_BVALID); end
    checks++; if (S_RVALID !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %b want 0", S_RVALID); end
    checks++; if (S_BRESP !== 2'b00) begin errors++; $display("FAIL rst_bresp got %b want 00", S_BRESP); end
    checks++; if (S_RRESP !== 2'b00) begin errors++; $display("FAIL rst_rresp got %b want 00", S_RRESP); end
    checks++; if (S_RDATA !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", S_RDATA); end
    checks++; if (S_AWREADY !== 1'b1) begin errors++; $display("FAIL rst_awready got %b want 1", S_AWREADY); end
    checks++; if (S_WREADY !== 1'b1) begin errors++; $display("FAIL rst_wready got %b want 1", S_WREADY); end
    checks++; if (S_ARREADY !== 1'b1) begin errors++; $display("FAIL rst_arready got %b want 1", S_ARREADY); end
  endtask

  task automatic test_simple_write_read();
    logic [31:0] d; logic [1:0] r;
    S_AWADDR = 32'h4; S_WDATA = 32'hDEADBEEF; S_WSTRB = 4'hF;
    S_AWVALID = 1; S_WVALID = 1; S_BREADY = 1;
    tick();
    S_AWVALID = 0; S_WVALID = 0;
    checks++; if (S_BVALID !== 1'b1) begin errors++; $display("FAIL wr4_bvalid got %b want 1", S_BVALID); end
    checks++; if (S_BRESP !== 2'b00) begin errors++; $display("FAIL wr4_bresp got %b want 00", S_BRESP); end
    tick();
    S_BREADY = 0;
    checks++; if (S_BVALID !== 1'b0) begin errors++; $display("FAIL wr4_bvalid_clear got %b want 0", S_BVALID); end
    do_read(32'h4, d, r);
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL rd4_data got %h want deadbeef", d); end
    checks++; if (r !== 2'b00) begin errors++; $display("FAIL rd4_resp got %b want 00", r); end
  endtask

  task automatic test_w_before_aw();
    logic [31:0] d; logic [1:0] r;
    do_write(32'h8, 32'hFFFFFFFF, 4'hF, r);
    S_WDATA = 32'h11223344; S_WSTRB = 4'h5; S_WVALID = 1; S_BREADY = 1;
    tick();
    S_WVALID = 0;
    checks++; if (S_WREADY !== 1'b0) begin errors++; $display("FAIL wfirst_wready got %b want 0", S_WREADY); end
    checks++; if (S_AWREADY !== 1'b1) begin errors++; $display("FAIL wfirst_awready got %b want 1", S_AWREADY); end
    checks++; if (S_BVALID !== 1'b0) begin errors++; $display("FAIL wfirst_bvalid_early got %b want 0", S_BVALID); end
    tick();
    S_AWADDR = 32'h8; S_AWVALID = 1;
    tick();
    S_AWVALID = 0;
    checks++; if (S_BVALID !== 1'b1) begin errors++; $display("FAIL wfirst_bvalid got %b want 1", S_BVALID); end
    tick();
    checks++; if (S_BVALID !== 1'b0) begin errors++; $display("FAIL wfirst_single_b got %b want 0", S_BVALID); end
    tick();
    checks++; if (S_BVALID !== 1'b0) begin errors++; $display("FAIL wfirst_no_second_b got %b want 0", S_BVALID); end
    S_BREADY = 0;
    do_read(32'h8, d, r);
    checks++; if (d !== 32'hFF22FF44) begin errors++; $display("FAIL wfirst_rdata got %h want ff22ff44", d); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d; logic [1:0] r;
    do_write(32'h40, 32'h12345678, 4'hF, r);
    checks++; if (r !== 2'b10) begin errors++; $display("FAIL oor_bresp got %b want 10", r); end
    do_read(32'h40, d, r);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL oor_rdata got %h want 0", d); end
    checks++; if (r !== 2'b10) begin errors++; $display("FAIL oor_rresp got %b want 10", r); end
    do_read(32'h0, d, r);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL oor_alias_reg0 got %h want 0", d); end
    do_read(32'h4, d, r);
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL oor_reg1_kept got %h want deadbeef", d); end
  endtask

  task automatic test_backpressure();
    S_AWADDR = 32'h10; S_WDATA = 32'h55AA55AA; S_WSTRB = 4'hF;
    S_AWVALID = 1; S_WVALID = 1; S_BREADY = 0;
    tick();
    S_AWVALID = 0; S_WVALID = 0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (S_BVALID !== 1'b1) begin errors++; $display("FAIL bp_bvalid[%0d] got %b want 1", i, S_BVALID); end
      checks++; if (S_BRESP !== 2'b00) begin errors++; $display("FAIL bp_bresp[%0d] got %b want 00", i, S_BRESP); end
      checks++; if ({S_AWREADY, S_WREADY} !== 2'b00) begin errors++; $display("FAIL bp_readies[%0d] got %b want 00", i, {S_AWREADY, S_WREADY}); end
      tick();
    end
    S_BREADY = 1;
    tick();
    S_BREADY = 0;
    checks++; if (S_BVALID !== 1'b0) begin errors++; $display("FAIL bp_bvalid_clear got %b want 0", S_BVALID); end
    checks++; if ({S_AWREADY, S_WREADY} !== 2'b11) begin errors++; $display("FAIL bp_readies_back got %b want 11", {S_AWREADY, S_WREADY}); end
    S_ARADDR = 32'h10; S_ARVALID = 1; S_RREADY = 0;
    tick();
    S_ARVALID = 0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (S_RVALID !== 1'b1) begin errors++; $display("FAIL bp_rvalid[%0d] got %b want 1", i, S_RVALID); end
      checks++; if (S_RDATA !== 32'h55AA55AA) begin errors++; $display("FAIL bp_rdata[%0d] got %h want 55aa55aa", i, S_RDATA); end
      checks++; if (S_ARREADY !== 1'b0) begin errors++; $display("FAIL bp_arready[%0d] got %b want 0", i, S_ARREADY); end
      tick();
    end
    S_RREADY = 1;
    tick();
    S_RREADY = 0;
    checks++; if (S_RVALID !== 1'b0) begin errors++; $display("FAIL bp_rvalid_clear got %b want 0", S_RVALID); end
    checks++; if (S_ARREADY !== 1'b1) begin errors++; $display("FAIL bp_arready_back got %b want 1", S_ARREADY); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] d; logic [1:0] r;
    S_WDATA = 32'hCAFEBABE; S_WSTRB = 4'hF; S_WVALID = 1; S_BREADY = 1;
    tick();
    S_WVALID = 0;
    S_AWADDR = 32'h14; S_AWVALID = 1; ARESET = 1;
    tick();
    S_AWVALID = 0; ARESET = 0;
    tick();
    checks++; if (S_BVALID !== 1'b0) begin errors++; $display("FAIL abort_bvalid got %b want 0", S_BVALID); end
    checks++; if ({S_AWREADY, S_WREADY, S_ARREADY} !== 3'b111) begin errors++; $display("FAIL abort_readies got %b want 111", {S_AWREADY, S_WREADY, S_ARREADY}); end
    tick();
    checks++; if (S_BVALID !== 1'b0) begin errors++; $display("FAIL abort_bvalid_late got %b want 0", S_BVALID); end
    S_BREADY = 0;
    do_read(32'h14, d, r);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL abort_target_reg got %h want 0", d); end
    do_read(32'h4, d, r);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL abort_reg_cleared got %h want 0", d); end
  endtask

  task automatic test_read_during_commit();
    logic [31:0] d; logic [1:0] r;
    S_AWADDR = 32'hC; S_WDATA = 32'hA5A5A5A5; S_WSTRB = 4'hF; S_ARADDR = 32'hC;
    S_AWVALID = 1; S_WVALID = 1; S_ARVALID = 1; S_BREADY = 1; S_RREADY = 1;
    tick();
    S_AWVALID = 0; S_WVALID = 0; S_ARVALID = 0;
    checks++; if (S_RVALID !== 1'b1) begin errors++; $display("FAIL race_rvalid got %b want 1", S_RVALID); end
    checks++; if (S_RDATA !== 32'h0) begin errors++; $display("FAIL race_old_value got %h want 0", S_RDATA); end
    checks++; if (S_BVALID !== 1'b1) begin errors++; $display("FAIL race_bvalid got %b want 1", S_BVALID); end
    tick();
    S_BREADY = 0; S_RREADY = 0;
    do_read(32'hC, d, r);
    checks++; if (d !== 32'hA5A5A5A5) begin errors++; $display("FAIL race_new_value got %h want a5a5a5a5", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic [1:0] r;
    do_write(32'h18, 32'h01020304, 4'hF, r);
    do_write(32'h1C, 32'h0A0B0C0D, 4'hF, r);
    do_write(32'h1B, 32'hAABBCCDD, 4'h8, r);
    checks++; if (r !== 2'b00) begin errors++; $display("FAIL b2b_bresp got %b want 00", r); end
    do_read(32'h18, d, r);
    checks++; if (d !== 32'hAA020304) begin errors++; $display("FAIL b2b_reg6 got %h want aa020304", d); end
    do_read(32'h1C, d, r);
    checks++; if (d !== 32'h0A0B0C0D) begin errors++; $display("FAIL b2b_reg7 got %h want 0a0b0c0d", d); end
  endtask

  initial begin
    ARESET = 1;
    S_AWADDR = '0; S_AWVALID = 0; S_WDATA = '0; S_WSTRB = '0; S_WVALID = 0; S_BREADY = 0;
    S_ARADDR = '0; S_ARVALID = 0; S_RREADY = 0;
    test_reset();
    test_simple_write_read();
    test_w_before_aw();
    test_out_of_range();
    test_backpressure();
    test_reset_abort();
    test_read_during_commit();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
